// File: rtl/acl_spi_responder.sv
// SPI mode-0 slave presenting an accelerometer-style register map.
// All SPI inputs are resynchronised to CLK; MISO is a registered output.
module acl_spi_responder (
    input  logic        CLK,
    input  logic        RST_BTN,
    input  logic        ACL_SCLK,
    input  logic        ACL_CSN,
    input  logic        ACL_MOSI,
    output logic        ACL_MISO,
    input  logic [11:0] X_IN,
    input  logic [11:0] Y_IN,
    input  logic [11:0] Z_IN,
    output logic        MEAS_EN
);
    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StRdata, StWdata, StIgnore} state_e;

    localparam logic [7:0] CmdRead    = 8'h0B;
    localparam logic [7:0] CmdWrite   = 8'h0A;
    localparam logic [5:0] AddrFilter = 6'h2C;
    localparam logic [5:0] AddrPower  = 6'h2D;

    state_e      state_q;
    logic [2:0]  sclk_q, csn_q;
    logic [1:0]  mosi_q;
    logic [1:0]  vld_q;
    logic        armed_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic [5:0]  ptr_q;
    logic        is_read_q;
    logic        miso_q;
    logic [7:0]  filter_q, power_q;
    logic        meas_en_q;
    logic [11:0] x_sh_q, y_sh_q, z_sh_q;

    logic       sclk_rise, sclk_fall, csn_fall, csn_rise;
    logic [7:0] shift_in;
    logic [7:0] rdata;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign csn_fall  = ~csn_q[1] & csn_q[2];
    assign csn_rise  = csn_q[1] & ~csn_q[2];
    assign shift_in  = {shift_q[6:0], mosi_q[1]};

    always_comb begin
        rdata = 8'h00;
        case (ptr_q)
            6'h00:      rdata = 8'hAD;
            6'h01:      rdata = 8'h1D;
            6'h02:      rdata = 8'hF2;
            6'h03:      rdata = 8'h01;
            6'h08:      rdata = x_sh_q[11:4];
            6'h09:      rdata = y_sh_q[11:4];
            6'h0A:      rdata = z_sh_q[11:4];
            6'h0E:      rdata = x_sh_q[7:0];
            6'h0F:      rdata = {{4{x_sh_q[11]}}, x_sh_q[11:8]};
            6'h10:      rdata = y_sh_q[7:0];
            6'h11:      rdata = {{4{y_sh_q[11]}}, y_sh_q[11:8]};
            6'h12:      rdata = z_sh_q[7:0];
            6'h13:      rdata = {{4{z_sh_q[11]}}, z_sh_q[11:8]};
            AddrFilter: rdata = filter_q;
            AddrPower:  rdata = power_q;
            default:    rdata = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST_BTN) begin
            state_q   <= StIdle;
            sclk_q    <= 3'b000;
            csn_q     <= 3'b111;
            mosi_q    <= 2'b00;
            vld_q     <= 2'd0;
            armed_q   <= 1'b0;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            ptr_q     <= 6'd0;
            is_read_q <= 1'b0;
            miso_q    <= 1'b0;
            filter_q  <= 8'h13;
            power_q   <= 8'h00;
            meas_en_q <= 1'b0;
            x_sh_q    <= 12'd0;
            y_sh_q    <= 12'd0;
            z_sh_q    <= 12'd0;
        end else begin
            sclk_q    <= {sclk_q[1:0], ACL_SCLK};
            csn_q     <= {csn_q[1:0], ACL_CSN};
            mosi_q    <= {mosi_q[0], ACL_MOSI};
            meas_en_q <= (power_q[1:0] == 2'b10);
            if (vld_q != 2'd2) vld_q <= vld_q + 2'd1;
            // Only a CSN high seen after reset arms us, so a transfer cut by reset is ignored.
            if (vld_q == 2'd2 && csn_q[1]) armed_q <= 1'b1;

            if (csn_rise) begin
                state_q   <= StIdle;
                bit_cnt_q <= 3'd0;
                miso_q    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        miso_q <= 1'b0;
                        if (csn_fall && armed_q) begin
                            state_q   <= StCmd;
                            bit_cnt_q <= 3'd0;
                            shift_q   <= 8'h00;
                            x_sh_q    <= X_IN;
                            y_sh_q    <= Y_IN;
                            z_sh_q    <= Z_IN;
                        end
                    end
                    StCmd: if (sclk_rise) begin
                        shift_q   <= shift_in;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            is_read_q <= (shift_in == CmdRead);
                            state_q   <= (shift_in == CmdRead || shift_in == CmdWrite) ?
                                         StAddr : StIgnore;
                        end
                    end
                    StAddr: if (sclk_rise) begin
                        shift_q   <= shift_in;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ptr_q   <= shift_in[5:0];
                            state_q <= is_read_q ? StRdata : StWdata;
                        end
                    end
                    StRdata: begin
                        // Falls with bit_cnt 0 start a new byte from the current pointer.
                        if (sclk_fall) begin
                            if (bit_cnt_q == 3'd0) begin
                                shift_q <= rdata;
                                miso_q  <= rdata[7];
                            end else begin
                                shift_q <= {shift_q[6:0], 1'b0};
                                miso_q  <= shift_q[6];
                            end
                        end
                        if (sclk_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) ptr_q <= ptr_q + 6'd1;
                        end
                    end
                    StWdata: if (sclk_rise) begin
                        shift_q   <= shift_in;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (ptr_q == AddrFilter) filter_q <= shift_in;
                            if (ptr_q == AddrPower)  power_q  <= shift_in;
                            ptr_q <= ptr_q + 6'd1;
                        end
                    end
                    StIgnore: miso_q <= 1'b0;
                    default:  state_q <= StIdle;
                endcase
            end
        end
    end

    assign ACL_MISO = miso_q;
    assign MEAS_EN  = meas_en_q;
endmodule

// File: tb/tb_acl_spi_responder.sv
// Directed bench for acl_spi_responder: acts as a slow mode-0 SPI master.
module tb_acl_spi_responder;
    localparam int Half = 8;

    logic        CLK = 1'b0;
    logic        RST_BTN = 1'b1;
    logic        ACL_SCLK = 1'b0;
    logic        ACL_CSN = 1'b1;
    logic        ACL_MOSI = 1'b0;
    logic        ACL_MISO;
    logic [11:0] X_IN = 12'd0;
    logic [11:0] Y_IN = 12'd0;
    logic [11:0] Z_IN = 12'd0;
    logic        MEAS_EN;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] rx;

    acl_spi_responder dut (
        .CLK      (CLK),
        .RST_BTN  (RST_BTN),
        .ACL_SCLK (ACL_SCLK),
        .ACL_CSN  (ACL_CSN),
        .ACL_MOSI (ACL_MOSI),
        .ACL_MISO (ACL_MISO),
        .X_IN     (X_IN),
        .Y_IN     (Y_IN),
        .Z_IN     (Z_IN),
        .MEAS_EN  (MEAS_EN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Shift n bits MSB first; MISO sampled just before each rising SCLK.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            ACL_MOSI = tx[7-i];
            wait_clk(Half);
            r = {r[6:0], ACL_MISO};
            ACL_SCLK = 1'b1;
            wait_clk(Half);
            ACL_SCLK = 1'b0;
        end
    endtask

    task automatic xchk(input string tag, input logic [7:0] tx, input logic [7:0] exp);
        logic [7:0] r;
        spi_bits(tx, 8, r);
        check(tag, r, exp);
    endtask

    task automatic cs_low();
        ACL_CSN = 1'b0;
        wait_clk(Half);
    endtask

    task automatic cs_high();
        wait_clk(Half);
        ACL_CSN  = 1'b1;
        ACL_MOSI = 1'b0;
        wait_clk(Half);
    endtask

    task automatic rd1(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        cs_low();
        xchk({tag, "_cmd"}, 8'h0B, 8'h00);
        xchk({tag, "_addr"}, addr, 8'h00);
        xchk(tag, 8'h00, exp);
        cs_high();
    endtask

    task automatic wr1(input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] r;
        cs_low();
        spi_bits(8'h0A, 8, r);
        spi_bits(addr, 8, r);
        spi_bits(data, 8, r);
        check("wr_miso_zero", r, 8'h00);
        cs_high();
    endtask

    initial begin
        wait_clk(3);
        check("rst_miso", {7'd0, ACL_MISO}, 8'h00);
        check("rst_meas", {7'd0, MEAS_EN}, 8'h00);
        RST_BTN = 1'b0;
        wait_clk(4);

        // Identity burst from 0x00
        cs_low();
        xchk("id_cmd", 8'h0B, 8'h00);
        xchk("id_addr", 8'h00, 8'h00);
        xchk("id_00", 8'h00, 8'hAD);
        xchk("id_01", 8'h00, 8'h1D);
        xchk("id_02", 8'h00, 8'hF2);
        cs_high();
        check("idle_miso", {7'd0, ACL_MISO}, 8'h00);
        check("meas_off", {7'd0, MEAS_EN}, 8'h00);

        // POWER_CTL write enables measurement
        wr1(8'h2D, 8'h02);
        check("meas_on", {7'd0, MEAS_EN}, 8'h01);
        rd1("pwr_rd", 8'h2D, 8'h02);
        rd1("filt_rst", 8'h2C, 8'h13);

        // Shadow capture: sample changes mid-transaction must not be seen
        X_IN = 12'h7F3;
        Y_IN = 12'h8A5;
        Z_IN = 12'h123;
        cs_low();
        xchk("sh_cmd", 8'h0B, 8'h00);
        X_IN = 12'h001;
        xchk("sh_addr", 8'h0E, 8'h00);
        xchk("x_lo", 8'h00, 8'hF3);
        xchk("x_hi", 8'h00, 8'h07);
        xchk("y_lo", 8'h00, 8'hA5);
        xchk("y_hi", 8'h00, 8'hF8);
        xchk("z_lo", 8'h00, 8'h23);
        xchk("z_hi", 8'h00, 8'h01);
        cs_high();
        cs_low();
        xchk("msb_cmd", 8'h0B, 8'h00);
        xchk("msb_addr", 8'h08, 8'h00);
        xchk("x_msb", 8'h00, 8'h00);
        xchk("y_msb", 8'h00, 8'h8A);
        xchk("z_msb", 8'h00, 8'h12);
        xchk("rsvd_0b", 8'h00, 8'h00);
        cs_high();

        // Aborted partial write leaves FILTER_CTL untouched
        cs_low();
        spi_bits(8'h0A, 8, rx);
        spi_bits(8'h2C, 8, rx);
        spi_bits(8'hFF, 5, rx);
        cs_high();
        rd1("filt_partial", 8'h2C, 8'h13);
        wr1(8'h2C, 8'h55);
        rd1("filt_wr", 8'h2C, 8'h55);
        wr1(8'h00, 8'h12);
        rd1("ro_00", 8'h00, 8'hAD);

        // Unknown command is ignored
        cs_low();
        xchk("ign_cmd", 8'h0D, 8'h00);
        xchk("ign_b1", 8'h2D, 8'h00);
        xchk("ign_b2", 8'h00, 8'h00);
        cs_high();
        rd1("pwr_keep", 8'h2D, 8'h02);

        // Pointer wraps 0x3F -> 0x00
        cs_low();
        xchk("wrap_cmd", 8'h0B, 8'h00);
        xchk("wrap_addr", 8'h3F, 8'h00);
        xchk("wrap_3f", 8'h00, 8'h00);
        xchk("wrap_00", 8'h00, 8'hAD);
        cs_high();

        // Reset during a read data byte
        cs_low();
        spi_bits(8'h0B, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 4, rx);
        RST_BTN = 1'b1;
        wait_clk(2);
        RST_BTN = 1'b0;
        wait_clk(1);
        check("rst_mid_miso", {7'd0, ACL_MISO}, 8'h00);
        check("rst_mid_meas", {7'd0, MEAS_EN}, 8'h00);
        spi_bits(8'h00, 8, rx);
        check("rst_mid_silent", rx, 8'h00);
        cs_high();
        rd1("post_rst_00", 8'h00, 8'hAD);
        rd1("post_rst_filt", 8'h2C, 8'h13);
        rd1("post_rst_pwr", 8'h2D, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
